vec_cmd_issuer: RTL and testbench
=================================

VEC_CMD_ISSUER -- requirements
Module: vec_cmd_issuer

Interface
REQ-001 Parameters SHALL be: els_p, default 8, number of vectors in the accelerator VRF; vlen_p, default 8, elements per vector; vdw_p, default 8, bits per element; fifo_depth_p, default 4, command FIFO entries (power of two, at least 2).
REQ-002 Derived widths SHALL be: aw = clog2(els_p); dw = vlen_p*vdw_p.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low. Ports follow, clock and reset first:
REQ-004 clk_i  in  1  clock.
REQ-005 reset_i  in  1  asynchronous, active-low reset.
REQ-006 cmd_v_i  in  1  host command valid.
REQ-007 cmd_ready_o  out  1  command FIFO can accept.
REQ-008 cmd_op_i  in  4  opcode.
REQ-009 cmd_addrA_i, cmd_addrB_i, cmd_addrD_i  in  aw each  operand and destination vector addresses.
REQ-010 cmd_scalar_i  in  vdw_p  scalar operand.
REQ-011 cmd_data_i  in  dw  write data.
REQ-012 op_o, addrA_o, addrB_o, addrD_o, scalar_o, w_data_o  out  4/aw/aw/aw/vdw_p/dw  fields driven to the accelerator.
REQ-013 acc_v_o  out  1  command valid to the accelerator; acc_ready_i  in  1  accelerator idle.
REQ-014 acc_done_i  in  1  accelerator done (its v_o); acc_data_i  in  dw  read data; acc_yumi_o  out  1  read data consumed.
REQ-015 resp_v_o  out  1; resp_data_o  out  dw; resp_yumi_i  in  1  host read-response handshake.
REQ-016 err_o  out  1  sticky illegal-opcode flag; issued_o, completed_o  out  8 each  wrapping command counters.

Function
REQ-017 Legal opcodes SHALL be 0000, 0001, 0010, 0100, 0101, 0110, 1000, 1001 and 1111; all others are illegal.
REQ-018 Enqueue SHALL occur when cmd_v_i & cmd_ready_o & the opcode is legal; cmd_ready_o = FIFO not full, independent of dequeue in the same cycle.
REQ-019 If the opcode is illegal, a handshake SHALL drop the command and set err_o, which stays set until reset.
REQ-020 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-021 IDLE -> ISSUE SHALL occur when the FIFO is non-empty.
REQ-022 In ISSUE, acc_v_o = acc_ready_i; ISSUE -> WAIT SHALL occur when acc_ready_i = 1.
REQ-023 WAIT, non-read opcode: on acc_done_i, the FIFO head SHALL be popped, completed_o SHALL increment, and the FSM SHALL go to IDLE.
REQ-024 WAIT, read opcode 1000: on acc_done_i, acc_yumi_o = 1 only if the response slot is empty or resp_yumi_i = 1 that cycle.
REQ-025 In that case acc_data_i SHALL be captured into resp_data_o, resp_v_o set, the head popped, completed_o incremented, and the FSM SHALL go to IDLE; otherwise the block stays in WAIT with acc_yumi_o = 0.
REQ-026 The op/addr/scalar/w_data outputs SHALL always reflect the FIFO head, combinationally, and stay stable from issue until pop; the accelerator reads addresses throughout its operation.
REQ-027 When the FIFO is empty, the op/addr/scalar/w_data outputs SHALL be 0.
REQ-028 issued_o SHALL increment on acc_v_o & acc_ready_i; both counters wrap 255 -> 0.
REQ-029 Minimum issue latency SHALL be: enqueue at cycle t -> acc_v_o at t+2 if acc_ready_i = 1.
REQ-030 Back-to-back commands SHALL have at least one IDLE cycle between pop and the next acc_v_o.
REQ-031 The response slot SHALL clear on resp_yumi_i & resp_v_o, unless refilled in the same cycle.
REQ-032 FIFO pointers SHALL wrap modulo fifo_depth_p, with full/empty distinguished by an extra pointer bit.
REQ-033 The module SHALL never assert acc_v_o while in WAIT, and SHALL never assert acc_yumi_o outside WAIT or for non-read opcodes.

Reset
REQ-034 Asserting reset_i low SHALL asynchronously force: FSM to IDLE; FIFO empty; cmd_ready_o = 1; acc_v_o = 0; acc_yumi_o = 0; resp_v_o = 0; resp_data_o = 0; err_o = 0; issued_o = 0; completed_o = 0.
REQ-035 Reset mid-operation SHALL discard all queued and in-flight commands; the accelerator is reset by the same reset.
REQ-036 Reset SHALL deassert synchronously to clk_i, and the first enqueue is accepted on the first rising edge after deassertion.

Verification
REQ-037 Single add: enqueue op 0000, A=1, B=2, D=3; acc_ready_i = 1 -> acc_v_o high one cycle at t+2 with addrA_o=1, addrB_o=2, addrD_o=3; acc_done_i 4 cycles later -> completed_o = 1, FIFO empty.
REQ-038 Read with full slot: resp_v_o already 1, resp_yumi_i = 0; read completes -> acc_yumi_o = 0, FSM holds WAIT; resp_yumi_i pulses -> same-cycle acc_yumi_o = 1 and resp_data_o = new acc_data_i.
REQ-039 FIFO full: enqueue 4 commands while acc_ready_i = 0 -> cmd_ready_o = 0; 5th cmd_v_i is not accepted; after one completion cmd_ready_o = 1.
REQ-040 Illegal opcode 0011 enqueued -> not stored, err_o = 1 and sticky, issued_o unchanged.
REQ-041 Reset pulse while in WAIT with 3 queued -> all outputs at reset values immediately; no acc_v_o after release until a new enqueue.
REQ-042 Counter wrap: 256 write (1001) commands -> issued_o = completed_o = 0.

Source files
------------

// File: rtl/vec_cmd_issuer.sv
// Host-to-accelerator command issuer: buffers host commands in a small FIFO, hands them to the
// vector accelerator one at a time and returns read data through a single-entry response slot.
module vec_cmd_issuer #(
  parameter int unsigned els_p        = 8,
  parameter int unsigned vlen_p       = 8,
  parameter int unsigned vdw_p        = 8,
  parameter int unsigned fifo_depth_p = 4,
  localparam int unsigned aw = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int unsigned dw = vlen_p * vdw_p
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cmd_v_i,
  output logic             cmd_ready_o,
  input  logic [3:0]       cmd_op_i,
  input  logic [aw-1:0]    cmd_addrA_i,
  input  logic [aw-1:0]    cmd_addrB_i,
  input  logic [aw-1:0]    cmd_addrD_i,
  input  logic [vdw_p-1:0] cmd_scalar_i,
  input  logic [dw-1:0]    cmd_data_i,
  output logic [3:0]       op_o,
  output logic [aw-1:0]    addrA_o,
  output logic [aw-1:0]    addrB_o,
  output logic [aw-1:0]    addrD_o,
  output logic [vdw_p-1:0] scalar_o,
  output logic [dw-1:0]    w_data_o,
  output logic             acc_v_o,
  input  logic             acc_ready_i,
  input  logic             acc_done_i,
  input  logic [dw-1:0]    acc_data_i,
  output logic             acc_yumi_o,
  output logic             resp_v_o,
  output logic [dw-1:0]    resp_data_o,
  input  logic             resp_yumi_i,
  output logic             err_o,
  output logic [7:0]       issued_o,
  output logic [7:0]       completed_o
);

  localparam int unsigned iw = (fifo_depth_p > 1) ? $clog2(fifo_depth_p) : 1;
  localparam logic [iw:0] PtrOne = 1;
  localparam logic [3:0]  OpRead = 4'b1000;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e           state_q;
  logic [iw:0]      wr_ptr_q, rd_ptr_q;
  logic [7:0]       issued_q, completed_q;
  logic             err_q;
  logic             resp_v_q;
  logic [dw-1:0]    resp_data_q;

  logic [3:0]       mem_op     [fifo_depth_p];
  logic [aw-1:0]    mem_a      [fifo_depth_p];
  logic [aw-1:0]    mem_b      [fifo_depth_p];
  logic [aw-1:0]    mem_d      [fifo_depth_p];
  logic [vdw_p-1:0] mem_scalar [fifo_depth_p];
  logic [dw-1:0]    mem_data   [fifo_depth_p];

  logic [iw-1:0]    wr_idx, rd_idx;
  logic             empty, full, legal, enq, bad_cmd;
  logic             head_is_read, slot_free, pop;

  assign wr_idx = wr_ptr_q[iw-1:0];
  assign rd_idx = rd_ptr_q[iw-1:0];

  // The extra MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[iw] != rd_ptr_q[iw]) && (wr_idx == rd_idx);

  always_comb begin
    legal = 1'b0;
    unique case (cmd_op_i)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
      4'b0110, 4'b1000, 4'b1001, 4'b1111: legal = 1'b1;
      default:                            legal = 1'b0;
    endcase
  end

  assign cmd_ready_o = ~full;
  assign enq         = cmd_v_i & ~full & legal;
  assign bad_cmd     = cmd_v_i & ~full & ~legal;

  assign head_is_read = (mem_op[rd_idx] == OpRead);
  assign slot_free    = ~resp_v_q | resp_yumi_i;

  assign acc_v_o    = (state_q == StIssue) & acc_ready_i;
  assign acc_yumi_o = (state_q == StWait) & head_is_read & acc_done_i & slot_free;
  assign pop        = (state_q == StWait) & acc_done_i & (~head_is_read | slot_free);

  // Head fields stay put from issue until pop; the accelerator samples them throughout.
  assign op_o     = empty ? '0 : mem_op[rd_idx];
  assign addrA_o  = empty ? '0 : mem_a[rd_idx];
  assign addrB_o  = empty ? '0 : mem_b[rd_idx];
  assign addrD_o  = empty ? '0 : mem_d[rd_idx];
  assign scalar_o = empty ? '0 : mem_scalar[rd_idx];
  assign w_data_o = empty ? '0 : mem_data[rd_idx];

  assign resp_v_o    = resp_v_q;
  assign resp_data_o = resp_data_q;
  assign err_o       = err_q;
  assign issued_o    = issued_q;
  assign completed_o = completed_q;

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_op[wr_idx]     <= cmd_op_i;
      mem_a[wr_idx]      <= cmd_addrA_i;
      mem_b[wr_idx]      <= cmd_addrB_i;
      mem_d[wr_idx]      <= cmd_addrD_i;
      mem_scalar[wr_idx] <= cmd_scalar_i;
      mem_data[wr_idx]   <= cmd_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      issued_q    <= '0;
      completed_q <= '0;
      err_q       <= 1'b0;
      resp_v_q    <= 1'b0;
      resp_data_q <= '0;
    end else begin
      if (enq)     wr_ptr_q <= wr_ptr_q + PtrOne;
      if (bad_cmd) err_q    <= 1'b1;
      if (acc_v_o) issued_q <= issued_q + 8'd1;

      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + PtrOne;
        completed_q <= completed_q + 8'd1;
      end

      if (acc_yumi_o) begin
        resp_v_q    <= 1'b1;
        resp_data_q <= acc_data_i;
      end else if (resp_v_q && resp_yumi_i) begin
        resp_v_q <= 1'b0;
      end

      unique case (state_q)
        StIdle:  if (!empty)     state_q <= StIssue;
        StIssue: if (acc_ready_i) state_q <= StWait;
        StWait:  if (pop)        state_q <= StIdle;
        default:                 state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_cmd_issuer.sv
// Directed self-checking bench for vec_cmd_issuer at default parameters.
module tb_vec_cmd_issuer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cmd_v = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [2:0]  cmd_a = '0, cmd_b = '0, cmd_d = '0;
  logic [7:0]  cmd_scalar = '0;
  logic [63:0] cmd_data = '0;
  logic [3:0]  op;
  logic [2:0]  addr_a, addr_b, addr_d;
  logic [7:0]  scalar;
  logic [63:0] w_data;
  logic        acc_v;
  logic        acc_ready = 1'b0;
  logic        acc_done = 1'b0;
  logic [63:0] acc_data = '0;
  logic        acc_yumi;
  logic        resp_v;
  logic [63:0] resp_data;
  logic        resp_yumi = 1'b0;
  logic        err;
  logic [7:0]  issued, completed;

  int n_checks = 0;
  int n_fail = 0;

  vec_cmd_issuer dut (
    .clk_i        (clk),
    .reset_i      (reset_n),
    .cmd_v_i      (cmd_v),
    .cmd_ready_o  (cmd_ready),
    .cmd_op_i     (cmd_op),
    .cmd_addrA_i  (cmd_a),
    .cmd_addrB_i  (cmd_b),
    .cmd_addrD_i  (cmd_d),
    .cmd_scalar_i (cmd_scalar),
    .cmd_data_i   (cmd_data),
    .op_o         (op),
    .addrA_o      (addr_a),
    .addrB_o      (addr_b),
    .addrD_o      (addr_d),
    .scalar_o     (scalar),
    .w_data_o     (w_data),
    .acc_v_o      (acc_v),
    .acc_ready_i  (acc_ready),
    .acc_done_i   (acc_done),
    .acc_data_i   (acc_data),
    .acc_yumi_o   (acc_yumi),
    .resp_v_o     (resp_v),
    .resp_data_o  (resp_data),
    .resp_yumi_i  (resp_yumi),
    .err_o        (err),
    .issued_o     (issued),
    .completed_o  (completed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [3:0] o, input logic [2:0] a, input logic [2:0] b,
                     input logic [2:0] d, input logic [7:0] s, input logic [63:0] data);
    cmd_op = o; cmd_a = a; cmd_b = b; cmd_d = d; cmd_scalar = s; cmd_data = data;
    cmd_v = 1'b1;
    cyc();
    cmd_v = 1'b0;
    #1;
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_cmd_ready"}, cmd_ready, 1);
    chk({pfx, "_acc_v"}, acc_v, 0);
    chk({pfx, "_acc_yumi"}, acc_yumi, 0);
    chk({pfx, "_resp_v"}, resp_v, 0);
    chk({pfx, "_resp_data"}, resp_data, 0);
    chk({pfx, "_err"}, err, 0);
    chk({pfx, "_issued"}, issued, 0);
    chk({pfx, "_completed"}, completed, 0);
    chk({pfx, "_op"}, op, 0);
    chk({pfx, "_w_data"}, w_data, 0);
  endtask

  logic [3:0] drain_ops [3];

  initial begin
    // Power-on reset
    #2 reset_n = 1'b0;
    #3;
    chk_reset_values("rst");
    @(negedge clk) reset_n = 1'b1;

    // Single add: issue two cycles after enqueue, completion four cycles after issue
    acc_ready = 1'b1;
    enq(4'b0000, 3'd1, 3'd2, 3'd3, 8'h11, 64'h1234);
    chk("add_t1_acc_v", acc_v, 0);
    chk("add_t1_head_a", addr_a, 1);
    cyc();
    chk("add_acc_v", acc_v, 1);
    chk("add_addr_a", addr_a, 1);
    chk("add_addr_b", addr_b, 2);
    chk("add_addr_d", addr_d, 3);
    chk("add_scalar", scalar, 8'h11);
    chk("add_w_data", w_data, 64'h1234);
    cyc();
    chk("add_wait_acc_v", acc_v, 0);
    chk("add_issued", issued, 1);
    cyc(); cyc(); cyc();
    acc_done = 1'b1; #1;
    chk("add_yumi_nonread", acc_yumi, 0);
    chk("add_addr_stable", addr_d, 3);
    cyc();
    acc_done = 1'b0; #1;
    chk("add_completed", completed, 1);
    chk("add_empty_op", addr_a, 0);
    chk("add_ready", cmd_ready, 1);
    chk("add_idle_acc_v", acc_v, 0);

    // Read into empty slot
    enq(4'b1000, 3'd5, 3'd0, 3'd0, 8'h00, 64'h0);
    cyc(); cyc();
    acc_data = 64'hA5A5_0000_1111_2222;
    acc_done = 1'b1; #1;
    chk("rd1_yumi", acc_yumi, 1);
    cyc();
    acc_done = 1'b0; #1;
    chk("rd1_resp_v", resp_v, 1);
    chk("rd1_resp_data", resp_data, 64'hA5A5_0000_1111_2222);
    chk("rd1_completed", completed, 2);

    // Read with the slot still full: stalls until the host consumes
    enq(4'b1000, 3'd6, 3'd0, 3'd0, 8'h00, 64'h0);
    cyc(); cyc();
    acc_data = 64'hB6B6_3333_4444_5555;
    acc_done = 1'b1; #1;
    chk("rd2_yumi_blocked", acc_yumi, 0);
    cyc();
    chk("rd2_hold_yumi", acc_yumi, 0);
    chk("rd2_hold_acc_v", acc_v, 0);
    chk("rd2_hold_data", resp_data, 64'hA5A5_0000_1111_2222);
    chk("rd2_hold_completed", completed, 2);
    resp_yumi = 1'b1; #1;
    chk("rd2_yumi_same_cycle", acc_yumi, 1);
    cyc();
    acc_done = 1'b0; resp_yumi = 1'b0; #1;
    chk("rd2_resp_data", resp_data, 64'hB6B6_3333_4444_5555);
    chk("rd2_resp_v_refill", resp_v, 1);
    chk("rd2_completed", completed, 3);
    resp_yumi = 1'b1;
    cyc();
    resp_yumi = 1'b0; #1;
    chk("rd2_resp_cleared", resp_v, 0);

    // FIFO full while the accelerator is busy
    acc_ready = 1'b0;
    enq(4'b0001, 3'd1, 3'd1, 3'd1, 8'h01, 64'h1);
    enq(4'b0010, 3'd2, 3'd2, 3'd2, 8'h02, 64'h2);
    enq(4'b0100, 3'd3, 3'd3, 3'd3, 8'h03, 64'h3);
    enq(4'b0101, 3'd4, 3'd4, 3'd4, 8'h04, 64'h4);
    chk("full_ready", cmd_ready, 0);
    chk("full_acc_v", acc_v, 0);
    enq(4'b0110, 3'd7, 3'd7, 3'd7, 8'h07, 64'h7);
    chk("full_5th_ready", cmd_ready, 0);
    chk("full_5th_err", err, 0);
    chk("full_head_op", op, 4'b0001);
    acc_ready = 1'b1; #1;
    chk("full_acc_v_ready", acc_v, 1);
    cyc();
    acc_done = 1'b1;
    cyc();
    acc_done = 1'b0; #1;
    chk("full_completed", completed, 4);
    chk("full_ready_after", cmd_ready, 1);
    chk("full_next_head", op, 4'b0010);
    chk("full_idle_gap", acc_v, 0);
    drain_ops[0] = 4'b0010;
    drain_ops[1] = 4'b0100;
    drain_ops[2] = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("drain_acc_v", acc_v, 1);
      chk("drain_op", op, drain_ops[i]);
      cyc();
      acc_done = 1'b1;
      cyc();
      acc_done = 1'b0; #1;
    end
    chk("drain_completed", completed, 7);
    chk("drain_issued", issued, 7);
    chk("drain_empty_op", op, 0);
    cyc(); cyc();
    chk("drain_no_5th", acc_v, 0);

    // Illegal opcode is dropped and latches err
    enq(4'b0011, 3'd1, 3'd2, 3'd3, 8'h33, 64'h33);
    chk("ill_err", err, 1);
    chk("ill_issued", issued, 7);
    chk("ill_not_stored", op, 0);
    chk("ill_ready", cmd_ready, 1);
    cyc(); cyc();
    chk("ill_err_sticky", err, 1);
    chk("ill_no_issue", acc_v, 0);
    chk("ill_issued_after", issued, 7);

    // Reset while in WAIT with three more queued
    acc_ready = 1'b1;
    enq(4'b1001, 3'd1, 3'd0, 3'd1, 8'h00, 64'hA);
    enq(4'b1001, 3'd2, 3'd0, 3'd2, 8'h00, 64'hB);
    enq(4'b1001, 3'd3, 3'd0, 3'd3, 8'h00, 64'hC);
    enq(4'b1001, 3'd4, 3'd0, 3'd4, 8'h00, 64'hD);
    chk("mid_full", cmd_ready, 0);
    chk("mid_wait_acc_v", acc_v, 0);
    chk("mid_issued", issued, 8);
    #2 reset_n = 1'b0;
    #1;
    chk_reset_values("mid_rst");
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("post_rst_acc_v", acc_v, 0);
    end

    // 256 writes wrap both counters
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        chk("wrap_issued_255", issued, 255);
        chk("wrap_completed_255", completed, 255);
      end
      enq(4'b1001, i[2:0], 3'd0, i[2:0], i[7:0], 64'(i));
      cyc();
      cyc();
      acc_done = 1'b1;
      cyc();
      acc_done = 1'b0; #1;
    end
    chk("wrap_issued", issued, 0);
    chk("wrap_completed", completed, 0);
    chk("wrap_empty", cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
